// File: rtl/regbank_pkg.sv
// regbank_pkg: shared definitions for the register bank.
//   DATA_W, NREG      : register width and count
//   reg_sel_t         : 4-bit register select
//   reg_onehot_t      : 16-bit per-register enable / mask
//   is_onehot()       : true when exactly one bit of a mask is set
package regbank_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 16;

  typedef logic [3:0]      reg_sel_t;
  typedef logic [NREG-1:0] reg_onehot_t;

  // Clearing the lowest set bit leaves zero only for a single-bit mask.
  function automatic logic is_onehot(input reg_onehot_t v);
    return (v != '0) && ((v & (v - reg_onehot_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// regbank_scoreboard: busy-bit scoreboard for the register bank.
//   clk, reset_n        : clock, asynchronous active-low reset
//   rsv_valid, rsv_sel  : mark a destination register busy
//   wr_hit              : registers being written this cycle (valid one-hot writes only)
//   a_sel, b_sel        : read source selects
//   busy                : scoreboard bits
//   a_blocked, b_blocked: the corresponding source cannot be read this cycle
// Build option: REGBANK_BYPASS_EN lets a same-cycle write unblock its register.
module regbank_scoreboard
  import regbank_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rsv_valid,
  input  reg_sel_t    rsv_sel,
  input  reg_onehot_t wr_hit,
  input  reg_sel_t    a_sel,
  input  reg_sel_t    b_sel,
  output reg_onehot_t busy,
  output logic        a_blocked,
  output logic        b_blocked
);

  reg_onehot_t rsv_hit;
  reg_onehot_t busy_next;
  reg_onehot_t blocked;

  always_comb begin
    rsv_hit   = rsv_valid ? (reg_onehot_t'(1) << rsv_sel) : '0;
    // A reserve represents a newer producer, so it overrides a same-cycle clear.
    busy_next = (busy & ~wr_hit) | rsv_hit;
`ifdef REGBANK_BYPASS_EN
    // The write being forwarded satisfies the reader unless a newer producer
    // is being reserved onto the same register in this cycle.
    blocked   = busy & ~(wr_hit & ~rsv_hit);
`else
    blocked   = busy;
`endif
    a_blocked = blocked[a_sel];
    b_blocked = blocked[b_sel];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_next;
  end

endmodule

// File: rtl/register_bank.sv
// register_bank: 16 x 32-bit register bank, two registered read ports,
// busy-bit scoreboard.
//   clk, reset_n              : clock, asynchronous active-low reset
//   wr_valid, wr_en_onehot,
//   wr_data                   : write-back port (one-hot enable from decoder)
//   rsv_valid, rsv_sel        : reserve a destination (sets busy)
//   rd_req, rd_a_sel, rd_b_sel: operand read request and source selects
//   rd_stall                  : combinational, read not accepted this cycle
//   rd_valid, rd_a_data,
//   rd_b_data                 : registered read response, data holds when idle
//   busy                      : scoreboard bits
//   onehot_err                : one-cycle pulse after a malformed write enable
// Handshake: a read is accepted in any cycle with rd_req=1 and rd_stall=0;
// the response appears with rd_valid=1 one cycle later. The requester keeps
// rd_req and the selects stable while rd_stall=1.
// Build option: REGBANK_BYPASS_EN forwards same-cycle write data to reads.
module register_bank #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  input  logic [NREG-1:0]       wr_en_onehot,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rsv_valid,
  input  regbank_pkg::reg_sel_t rsv_sel,
  input  logic                  rd_req,
  input  regbank_pkg::reg_sel_t rd_a_sel,
  input  regbank_pkg::reg_sel_t rd_b_sel,
  output logic                  rd_stall,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_a_data,
  output logic [DATA_W-1:0]     rd_b_data,
  output logic [NREG-1:0]       busy,
  output logic                  onehot_err
);

  import regbank_pkg::*;

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_ok;
  reg_onehot_t       wr_hit;
  logic              a_blocked;
  logic              b_blocked;
  logic              rd_accept;
  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] b_val;

  // Malformed enables (zero or several bits) are dropped entirely.
  assign wr_ok     = wr_valid & is_onehot(wr_en_onehot);
  assign wr_hit    = wr_ok ? wr_en_onehot : '0;
  assign rd_stall  = rd_req & (a_blocked | b_blocked);
  assign rd_accept = rd_req & ~rd_stall;

  regbank_scoreboard u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .rsv_valid(rsv_valid),
    .rsv_sel  (rsv_sel),
    .wr_hit   (wr_hit),
    .a_sel    (rd_a_sel),
    .b_sel    (rd_b_sel),
    .busy     (busy),
    .a_blocked(a_blocked),
    .b_blocked(b_blocked)
  );

  always_comb begin
    a_val = regs[rd_a_sel];
    b_val = regs[rd_b_sel];
`ifdef REGBANK_BYPASS_EN
    if (wr_hit[rd_a_sel]) a_val = wr_data;
    if (wr_hit[rd_b_sel]) b_val = wr_data;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_hit[i]) regs[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid   <= 1'b0;
      rd_a_data  <= '0;
      rd_b_data  <= '0;
      onehot_err <= 1'b0;
    end else begin
      rd_valid   <= rd_accept;
      onehot_err <= wr_valid & ~is_onehot(wr_en_onehot);
      if (rd_accept) begin
        rd_a_data <= a_val;
        rd_b_data <= b_val;
      end
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed test-plan steps plus a randomized phase,
// checked against a cycle-level model of the register bank behaviour.
// Honours REGBANK_BYPASS_EN the same way as the design.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic [15:0] wr_en_onehot;
  logic [31:0] wr_data;
  logic        rsv_valid;
  logic [3:0]  rsv_sel;
  logic        rd_req;
  logic [3:0]  rd_a_sel;
  logic [3:0]  rd_b_sel;
  logic        rd_stall;
  logic        rd_valid;
  logic [31:0] rd_a_data;
  logic [31:0] rd_b_data;
  logic [15:0] busy;
  logic        onehot_err;

  // clock / reset
  always #5 clk = ~clk;

  register_bank dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_valid    (wr_valid),
    .wr_en_onehot(wr_en_onehot),
    .wr_data     (wr_data),
    .rsv_valid   (rsv_valid),
    .rsv_sel     (rsv_sel),
    .rd_req      (rd_req),
    .rd_a_sel    (rd_a_sel),
    .rd_b_sel    (rd_b_sel),
    .rd_stall    (rd_stall),
    .rd_valid    (rd_valid),
    .rd_a_data   (rd_a_data),
    .rd_b_data   (rd_b_data),
    .busy        (busy),
    .onehot_err  (onehot_err)
  );

  // reference model state
  logic [31:0] m_regs [16];
  bit          m_busy [16];
  bit          m_rd_valid;
  logic [31:0] m_a;
  logic [31:0] m_b;
  bit          m_err;
  bit          last_stall;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] model_busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_rd_valid = 1'b0;
    m_a        = '0;
    m_b        = '0;
    m_err      = 1'b0;
    last_stall = 1'b0;
  endtask

  task automatic idle();
    wr_valid     = 1'b0;
    wr_en_onehot = '0;
    wr_data      = '0;
    rsv_valid    = 1'b0;
    rsv_sel      = '0;
    rd_req       = 1'b0;
    rd_a_sel     = '0;
    rd_b_sel     = '0;
  endtask

  // Index of the single enabled register, or -1 when the write is dropped.
  function automatic int write_target();
    if (!wr_valid || $countones(wr_en_onehot) != 1) return -1;
    for (int i = 0; i < 16; i++) if (wr_en_onehot[i]) return i;
    return -1;
  endfunction

  function automatic bit src_blocked(input int r);
`ifdef REGBANK_BYPASS_EN
    // A same-cycle write to r satisfies the reader unless r is re-reserved.
    if (write_target() == r && !(rsv_valid && int'(rsv_sel) == r)) return 1'b0;
`endif
    return m_busy[r];
  endfunction

  function automatic logic [31:0] operand(input int r);
`ifdef REGBANK_BYPASS_EN
    if (write_target() == r) return wr_data;
`endif
    return m_regs[r];
  endfunction

  // Called just after a rising edge with inputs already driven; checks the
  // combinational stall mid-cycle, advances the model over the next edge and
  // checks the registered outputs just after it.
  task automatic step();
    bit exp_stall;
    bit accept;
    int wt;
    @(negedge clk);
    wt        = write_target();
    exp_stall = rd_req && (src_blocked(int'(rd_a_sel)) || src_blocked(int'(rd_b_sel)));
    chk("rd_stall", {31'b0, rd_stall}, {31'b0, exp_stall});
    accept     = rd_req && !exp_stall;
    m_rd_valid = accept;
    if (accept) begin
      m_a = operand(int'(rd_a_sel));
      m_b = operand(int'(rd_b_sel));
    end
    m_err = wr_valid && (wt < 0);
    if (wt >= 0) begin
      m_regs[wt] = wr_data;
      m_busy[wt] = 1'b0;
    end
    if (rsv_valid) m_busy[rsv_sel] = 1'b1;
    last_stall = exp_stall;
    @(posedge clk);
    #1;
    chk("rd_valid",   {31'b0, rd_valid},   {31'b0, m_rd_valid});
    chk("rd_a_data",  rd_a_data,           m_a);
    chk("rd_b_data",  rd_b_data,           m_b);
    chk("onehot_err", {31'b0, onehot_err}, {31'b0, m_err});
    chk("busy",       {16'b0, busy},       {16'b0, model_busy_vec()});
  endtask

  task automatic do_write(input int r, input logic [31:0] d);
    idle();
    wr_valid     = 1'b1;
    wr_en_onehot = 16'(1) << r;
    wr_data      = d;
    step();
  endtask

  task automatic do_read(input int a, input int b);
    idle();
    rd_req   = 1'b1;
    rd_a_sel = 4'(a);
    rd_b_sel = 4'(b);
    step();
  endtask

  initial begin
    idle();
    model_reset();
    reset_n = 1'b0;
    #1;
    chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("reset_a",        rd_a_data,         32'd0);
    chk("reset_busy",     {16'b0, busy},     32'd0);
    chk("reset_err",      {31'b0, onehot_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // write R5, read R5/R0
    do_write(5, 32'hDEADBEEF);
    do_read(5, 0);
    chk("r5_read_a", rd_a_data, 32'hDEADBEEF);
    chk("r5_read_b", rd_b_data, 32'h0);

    // reserve R3, stall on it, then resolve with a write
    idle();
    rsv_valid = 1'b1;
    rsv_sel   = 4'd3;
    step();
    for (int k = 0; k < 3; k++) begin
      do_read(3, 0);
      chk("r3_stalled", {31'b0, rd_valid}, 32'd0);
    end
    idle();
    rd_req       = 1'b1;
    rd_a_sel     = 4'd3;
    wr_valid     = 1'b1;
    wr_en_onehot = 16'h0008;
    wr_data      = 32'h12345678;
    step();
`ifndef REGBANK_BYPASS_EN
    chk("r3_nobypass_wait", {31'b0, rd_valid}, 32'd0);
    do_read(3, 0);
`endif
    chk("r3_accepted", {31'b0, rd_valid}, 32'd1);
    chk("r3_data",     rd_a_data,         32'h12345678);

    // malformed write enables
    idle();
    wr_valid     = 1'b1;
    wr_en_onehot = 16'h0003;
    wr_data      = 32'hFFFF_0000;
    step();
    chk("err_two_bits", {31'b0, onehot_err}, 32'd1);
    wr_en_onehot = 16'h0000;
    step();
    chk("err_zero_bits", {31'b0, onehot_err}, 32'd1);
    idle();
    step();
    chk("err_pulse_end", {31'b0, onehot_err}, 32'd0);
    do_read(0, 1);
    chk("r0_unchanged", rd_a_data, 32'd0);
    chk("r1_unchanged", rd_b_data, 32'd0);

    // reserve and write R7 together: reserve wins
    idle();
    rsv_valid    = 1'b1;
    rsv_sel      = 4'd7;
    wr_valid     = 1'b1;
    wr_en_onehot = 16'h0080;
    wr_data      = 32'hA5A5A5A5;
    step();
    chk("r7_busy", {31'b0, busy[7]}, 32'd1);
    do_read(7, 7);
    chk("r7_stalled", {31'b0, rd_valid}, 32'd0);
    do_write(7, 32'hA5A5A5A5);
    do_read(7, 7);
    chk("r7_data", rd_a_data, 32'hA5A5A5A5);

    // accepted read followed immediately by reset
    do_write(2, 32'h00000042);
    do_read(2, 2);
    chk("r2_data", rd_b_data, 32'h00000042);
    idle();
    rsv_valid = 1'b1;
    rsv_sel   = 4'd9;
    rd_req    = 1'b1;
    rd_a_sel  = 4'd2;
    rd_b_sel  = 4'd2;
    reset_n   = 1'b0;
    #1;
    chk("mid_reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("mid_reset_a",        rd_a_data,         32'd0);
    chk("mid_reset_b",        rd_b_data,         32'd0);
    chk("mid_reset_busy",     {16'b0, busy},     32'd0);
    model_reset();
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    do_read(2, 5);
    chk("post_reset_r2", rd_a_data, 32'd0);
    chk("post_reset_r5", rd_b_data, 32'd0);

    // fill all registers, then read mirrored pairs without stalls
    for (int i = 0; i < 16; i++) do_write(i, 32'h100 + 32'(i));
    for (int i = 0; i < 16; i++) begin
      do_read(i, 15 - i);
      chk("pair_valid", {31'b0, rd_valid}, 32'd1);
      chk("pair_a", rd_a_data, 32'h100 + 32'(i));
      chk("pair_b", rd_b_data, 32'h100 + 32'(15 - i));
    end

    // randomized traffic; reads hold their request while stalled
    idle();
    for (int n = 0; n < 400; n++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) wr_en_onehot = 16'($urandom);
      else                           wr_en_onehot = 16'(1) << $urandom_range(0, 15);
      wr_data   = $urandom;
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_sel   = 4'($urandom_range(0, 15));
      if (!last_stall) begin
        rd_req   = ($urandom_range(0, 1) == 1);
        rd_a_sel = 4'($urandom_range(0, 15));
        rd_b_sel = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
